// File: rtl/sweep_acq_pkg.sv
// Shared state encoding and framing constants for the multi-DAC S-curve sweep controller.
package sweep_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_SC  = 3'd1,
    ST_WAIT_CFG = 3'd2,
    ST_HEADER   = 3'd3,
    ST_ACQ      = 3'd4,
    ST_DRAIN    = 3'd5,
    ST_NEXT     = 3'd6,
    ST_DONE     = 3'd7
  } state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;
  localparam logic [3:0] TRL_TAG = 4'hF;
  localparam logic [2:0] DRAIN_IDLE = 3'd4;

endpackage

// File: rtl/sweep_dac_stepper.sv
// Holds the sweep limits and step, the current DAC value, and a registered
// flag telling whether the current value is the last point of the sweep.
module sweep_dac_stepper #(
  parameter int DAC_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 advance,
  input  logic [DAC_WIDTH-1:0] start_dac,
  input  logic [DAC_WIDTH-1:0] end_dac,
  input  logic [DAC_WIDTH-1:0] step,
  output logic [DAC_WIDTH-1:0] dac,
  output logic                 last_point
);

  logic [DAC_WIDTH-1:0] dac_d, dac_q, end_d, end_q, step_d, step_q;
  logic                 last_d, last_q;
  logic [DAC_WIDTH:0]   sum_s;

  // The extra adder bit makes an overflowing step compare greater than any end value.
  always_comb begin
    dac_d  = dac_q;
    end_d  = end_q;
    step_d = step_q;
    sum_s  = {1'b0, dac_q} + {1'b0, step_q};
    last_d = (sum_s > {1'b0, end_q});
    if (load) begin
      dac_d  = start_dac;
      end_d  = end_dac;
      step_d = (step == '0) ? {{(DAC_WIDTH-1){1'b0}}, 1'b1} : step;
    end else if (advance) begin
      dac_d = sum_s[DAC_WIDTH-1:0];
    end else begin
      dac_d = dac_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_q  <= '0;
      end_q  <= '0;
      step_q <= '0;
      last_q <= 1'b0;
    end else begin
      dac_q  <= dac_d;
      end_q  <= end_d;
      step_q <= step_d;
      last_q <= last_d;
    end
  end

  assign dac        = dac_q;
  assign last_point = last_q;

endmodule

// File: rtl/sweep_acq_ctrl_multi.sv
// Sweeps one selectable threshold DAC, reloading slow control and running one
// acquisition per point while streaming header, FIFO data and trailer words.
module sweep_acq_ctrl_multi
  import sweep_acq_pkg::*;
#(
  parameter int DAC_WIDTH     = 10,
  parameter int NUM_DAC       = 3,
  parameter int DATA_WIDTH    = 16,
  parameter int PKG_CNT_WIDTH = 16,
  parameter int CFG_TIMEOUT   = 4096,
  localparam int SEL_W        = $clog2(NUM_DAC)
) (
  input  logic                     Clk,
  input  logic                     reset_n,
  input  logic                     SweepStart,
  input  logic                     SweepAbort,
  input  logic [SEL_W-1:0]         DACSelect,
  input  logic [DAC_WIDTH-1:0]     StartDAC,
  input  logic [DAC_WIDTH-1:0]     EndDAC,
  input  logic [DAC_WIDTH-1:0]     DACStep,
  input  logic [PKG_CNT_WIDTH-1:0] MaxPackageNumber,
  input  logic                     ParallelData_en,
  input  logic                     MicrorocConfigDone,
  input  logic [DATA_WIDTH-1:0]    SweepACQFifoData,
  input  logic                     SweepACQFifoEmpty,
  input  logic                     SweepACQData_afull,
  output logic [DAC_WIDTH-1:0]     OutDAC,
  output logic [SEL_W-1:0]         OutDACSelect,
  output logic                     LoadSCParameter,
  output logic                     SingleACQStart,
  output logic                     SweepACQFifoData_rden,
  output logic [DATA_WIDTH-1:0]    SweepACQData,
  output logic                     SweepACQData_en,
  output logic                     OneDACDone,
  output logic                     ACQDone,
  output logic                     SweepBusy,
  output logic                     CfgTimeoutErr
);

  localparam int TMO_W = $clog2(CFG_TIMEOUT) + 1;

  state_e                   state_d, state_q;
  logic [SEL_W-1:0]         sel_d, sel_q;
  logic [PKG_CNT_WIDTH-1:0] max_d, max_q, pkg_d, pkg_q, pkg_inc_s;
  logic [TMO_W-1:0]         tmo_d, tmo_q;
  logic [2:0]               idle_d, idle_q;
  logic [DATA_WIDTH-1:0]    word_d, word_q, hdr_s, trl_s;
  logic load_sc_d, load_sc_q, acq_start_d, acq_start_q, one_done_d, one_done_q;
  logic acq_done_d, acq_done_q, busy_d, busy_q, err_d, err_q, word_en_d, word_en_q;
  logic rd_pend_q, rden_s, step_load_s, step_adv_s, last_point_s;
  logic [DAC_WIDTH-1:0] dac_s;

  sweep_dac_stepper #(.DAC_WIDTH(DAC_WIDTH)) u_stepper (
    .clk        (Clk),
    .rst_n      (reset_n),
    .load       (step_load_s),
    .advance    (step_adv_s),
    .start_dac  (StartDAC),
    .end_dac    (EndDAC),
    .step       (DACStep),
    .dac        (dac_s),
    .last_point (last_point_s)
  );

  assign rden_s = ((state_q == ST_ACQ) || (state_q == ST_DRAIN)) &&
                  !SweepACQFifoEmpty && !SweepACQData_afull;

  always_comb begin
    hdr_s = '0;
    hdr_s[DATA_WIDTH-1 -: 4] = HDR_TAG;
    hdr_s[SEL_W+DAC_WIDTH-1:0] = {sel_q, dac_s};
    trl_s = '0;
    trl_s[DATA_WIDTH-1 -: 4] = TRL_TAG;
    if (ParallelData_en && (pkg_q != max_q)) begin
      pkg_inc_s = pkg_q + PKG_CNT_WIDTH'(1);
    end else begin
      pkg_inc_s = pkg_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    max_d       = max_q;
    pkg_d       = pkg_q;
    tmo_d       = tmo_q;
    idle_d      = idle_q;
    err_d       = err_q;
    word_d      = word_q;
    load_sc_d   = 1'b0;
    one_done_d  = 1'b0;
    acq_done_d  = 1'b0;
    word_en_d   = 1'b0;
    step_load_s = 1'b0;
    step_adv_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (SweepStart) begin
          err_d       = 1'b0;
          sel_d       = DACSelect;
          max_d       = (MaxPackageNumber == '0) ? PKG_CNT_WIDTH'(1) : MaxPackageNumber;
          step_load_s = 1'b1;
          state_d     = ST_LOAD_SC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD_SC: begin
        load_sc_d = 1'b1;
        tmo_d     = '0;
        state_d   = ST_WAIT_CFG;
      end
      ST_WAIT_CFG: begin
        if (SweepAbort) begin
          state_d = ST_DONE;
        end else if (MicrorocConfigDone) begin
          state_d = ST_HEADER;
        end else if (tmo_q == TMO_W'(CFG_TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_HEADER: begin
        pkg_d = '0;
        if (!SweepACQData_afull) begin
          word_en_d = 1'b1;
          word_d    = hdr_s;
          state_d   = ST_ACQ;
        end else begin
          state_d = ST_HEADER;
        end
      end
      ST_ACQ: begin
        pkg_d  = pkg_inc_s;
        idle_d = 3'd0;
        if ((pkg_inc_s == max_q) || SweepAbort) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_ACQ;
        end
      end
      // A read issued last cycle still owes a word, so it breaks the idle run.
      ST_DRAIN: begin
        if (SweepACQFifoEmpty && !rd_pend_q) begin
          if (idle_q == DRAIN_IDLE - 3'd1) begin
            idle_d  = 3'd0;
            state_d = ST_NEXT;
          end else begin
            idle_d = idle_q + 3'd1;
          end
        end else begin
          idle_d = 3'd0;
        end
      end
      ST_NEXT: begin
        one_done_d = 1'b1;
        if (SweepAbort || last_point_s) begin
          state_d = ST_DONE;
        end else begin
          step_adv_s = 1'b1;
          state_d    = ST_LOAD_SC;
        end
      end
      ST_DONE: begin
        if (!SweepACQData_afull) begin
          word_en_d  = 1'b1;
          word_d     = trl_s;
          acq_done_d = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    acq_start_d = (state_d == ST_ACQ);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      max_q       <= '0;
      pkg_q       <= '0;
      tmo_q       <= '0;
      idle_q      <= 3'd0;
      err_q       <= 1'b0;
      word_q      <= '0;
      load_sc_q   <= 1'b0;
      acq_start_q <= 1'b0;
      one_done_q  <= 1'b0;
      acq_done_q  <= 1'b0;
      busy_q      <= 1'b0;
      word_en_q   <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      max_q       <= max_d;
      pkg_q       <= pkg_d;
      tmo_q       <= tmo_d;
      idle_q      <= idle_d;
      err_q       <= err_d;
      word_q      <= word_d;
      load_sc_q   <= load_sc_d;
      acq_start_q <= acq_start_d;
      one_done_q  <= one_done_d;
      acq_done_q  <= acq_done_d;
      busy_q      <= busy_d;
      word_en_q   <= word_en_d;
      rd_pend_q   <= rden_s;
    end
  end

  // FIFO words arrive one cycle after the strobe and bypass the framing register.
  assign SweepACQData          = rd_pend_q ? SweepACQFifoData : word_q;
  assign SweepACQData_en       = rd_pend_q | word_en_q;
  assign SweepACQFifoData_rden = rden_s;
  assign OutDAC                = dac_s;
  assign OutDACSelect          = sel_q;
  assign LoadSCParameter       = load_sc_q;
  assign SingleACQStart        = acq_start_q;
  assign OneDACDone            = one_done_q;
  assign ACQDone               = acq_done_q;
  assign SweepBusy             = busy_q;
  assign CfgTimeoutErr         = err_q;

endmodule
